// File: rtl/key_debounce.sv
// Two-channel push-button conditioner: 2-flop synchronizer, debounce FSM and
// press/auto-repeat pulse generator per key. Key bit0 = up, bit1 = down.
`timescale 1ns/1ps

module key_debounce #(
   parameter int DB_CYCLES  = 50000,
   parameter int REP_DELAY  = 25000000,
   parameter int REP_PERIOD = 5000000,
   parameter int REP_EN     = 1,
   parameter int CNT_W      = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] key_n,
   output logic       KEY_UP,
   output logic       KEY_DOWN,
   output logic       up_pulse,
   output logic       down_pulse
);

   localparam int CNT_MAX_A = (DB_CYCLES > REP_DELAY) ? DB_CYCLES : REP_DELAY;
   localparam int CNT_MAX   = (CNT_MAX_A > REP_PERIOD) ? CNT_MAX_A : REP_PERIOD;

   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

   generate
      if (CNT_W < $clog2(CNT_MAX + 1)) begin : g_cnt_w_check
         $error("key_debounce: CNT_W too small for DB_CYCLES/REP_DELAY/REP_PERIOD");
      end
      if (DB_CYCLES < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
         $error("key_debounce: cycle parameters must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_REPEAT,
      ST_RELEASE_WAIT
   } state_t;

   logic [1:0] w_level;
   logic [1:0] w_pulse;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         logic             r_sync1;
         logic             r_sync2;
         logic             r_level;
         logic             r_pulse;
         logic [CNT_W-1:0] r_cnt;
         state_t           r_state;
         logic             w_s;

         // Synchronizers reset to the released level so reset release is quiet.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync1 <= 1'b1;
               r_sync2 <= 1'b1;
            end else begin
               r_sync1 <= key_n[gi];
               r_sync2 <= r_sync1;
            end
         end

         assign w_s = ~r_sync2;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_level <= 1'b0;
               r_pulse <= 1'b0;
            end else begin
               r_pulse <= 1'b0;
               case (r_state)
                  ST_IDLE: begin
                     r_level <= 1'b0;
                     r_cnt   <= '0;
                     if (w_s) begin
                        r_state <= ST_PRESS_WAIT;
                     end
                  end
                  ST_PRESS_WAIT: begin
                     if (!w_s) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                     end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_HELD;
                        r_level <= 1'b1;
                        r_pulse <= 1'b1;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  ST_HELD: begin
                     r_level <= 1'b1;
                     if (!w_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                     end else if (REP_EN != 0) begin
                        if (r_cnt == DELAY_LAST) begin
                           r_state <= ST_REPEAT;
                           r_pulse <= 1'b1;
                           r_cnt   <= '0;
                        end else begin
                           r_cnt <= r_cnt + 1'b1;
                        end
                     end
                  end
                  ST_REPEAT: begin
                     r_level <= 1'b1;
                     if (!w_s) begin
                        r_state <= ST_RELEASE_WAIT;
                        r_cnt   <= '0;
                     end else if (r_cnt == PERIOD_LAST) begin
                        r_pulse <= 1'b1;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  ST_RELEASE_WAIT: begin
                     // A bounce back to pressed restarts the repeat delay silently.
                     if (w_s) begin
                        r_state <= ST_HELD;
                        r_cnt   <= '0;
                     end else if (r_cnt == DB_LAST) begin
                        r_state <= ST_IDLE;
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
                  default: begin
                     r_state <= ST_IDLE;
                     r_level <= 1'b0;
                     r_cnt   <= '0;
                  end
               endcase
            end
         end

         assign w_level[gi] = r_level;
         assign w_pulse[gi] = r_pulse;
      end
   endgenerate

   assign KEY_UP     = w_level[0];
   assign KEY_DOWN   = w_level[1];
   assign up_pulse   = w_pulse[0];
   assign down_pulse = w_pulse[1];

endmodule
